// File: rtl/ascii_to_binary.sv
// Decodes a character stream of the form [sign] digits terminator into a signed
// BIN_WIDTH-bit value with saturation and an error flag, one character per handshake.
module ascii_to_binary #(
    parameter int BIN_WIDTH  = 12,
    parameter int MAX_DIGITS = 4,
    parameter int ACC_WIDTH  = BIN_WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 char_valid,
    input  logic [7:0]           char_in,
    output logic                 char_ready,
    output logic [BIN_WIDTH-1:0] bin_out,
    output logic                 is_negative,
    output logic                 error,
    output logic                 valid
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [ACC_WIDTH-1:0] LIM_POS = ACC_WIDTH'((1 << (BIN_WIDTH - 1)) - 1);
    localparam logic [ACC_WIDTH-1:0] LIM_NEG = ACC_WIDTH'(1 << (BIN_WIDTH - 1));
    localparam logic [BIN_WIDTH-1:0] SAT_POS = {1'b0, {(BIN_WIDTH - 1){1'b1}}};
    localparam logic [BIN_WIDTH-1:0] SAT_NEG = {1'b1, {(BIN_WIDTH - 1){1'b0}}};
    localparam logic [BIN_WIDTH-1:0] ZERO_B  = {BIN_WIDTH{1'b0}};
    localparam logic [ACC_WIDTH-1:0] ZERO_A  = {ACC_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SIGNED = 3'd1,
        S_DIGITS = 3'd2,
        S_ERR    = 3'd3,
        S_FINISH = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   r_neg;
    logic                   w_neg_nxt;
    logic                   r_err_flag;
    logic                   w_err_nxt;
    logic                   r_rdy;
    logic [BIN_WIDTH-1:0]   r_res;
    logic                   r_res_neg;
    logic                   r_res_err;
    logic [BIN_WIDTH-1:0]   w_res;
    logic                   w_res_neg;
    logic                   w_res_err;

    logic                   w_is_digit;
    logic                   w_is_sign;
    logic                   w_is_term;
    logic                   w_accept;
    logic [ACC_WIDTH-1:0]   w_digit;
    logic [ACC_WIDTH-1:0]   w_acc_x10;
    logic [BIN_WIDTH-1:0]   w_mag;

    assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_is_sign  = (char_in == 8'h2D) || (char_in == 8'h2B);
    assign w_is_term  = (char_in == 8'h0D) || (char_in == 8'h0A) || (char_in == 8'h20);
    assign char_ready = enable & r_rdy;
    assign w_accept   = enable & char_valid & char_ready;
    assign w_digit    = {{(ACC_WIDTH - 4){1'b0}}, char_in[3:0]};
    assign w_acc_x10  = {r_acc[ACC_WIDTH-4:0], 3'b000} + {r_acc[ACC_WIDTH-2:0], 1'b0};
    assign w_mag      = r_acc[BIN_WIDTH-1:0];

    // Next-state and datapath update for the parser FSM
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_neg_nxt   = r_neg;
        w_err_nxt   = r_err_flag;
        case (r_state)
            S_IDLE: begin
                if (!w_accept || w_is_term) begin
                    w_state_nxt = r_state;
                end else if (w_is_sign) begin
                    w_neg_nxt   = (char_in == 8'h2D);
                    w_state_nxt = S_SIGNED;
                end else if (w_is_digit) begin
                    w_acc_nxt   = w_digit;
                    w_count_nxt = CNT_W'(1);
                    w_state_nxt = S_DIGITS;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_SIGNED: begin
                if (!w_accept) begin
                    w_state_nxt = r_state;
                end else if (w_is_digit) begin
                    w_acc_nxt   = w_digit;
                    w_count_nxt = CNT_W'(1);
                    w_state_nxt = S_DIGITS;
                end else if (w_is_term) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DIGITS: begin
                if (!w_accept) begin
                    w_state_nxt = r_state;
                end else if (w_is_digit && (r_count < CNT_W'(MAX_DIGITS))) begin
                    w_acc_nxt   = w_acc_x10 + w_digit;
                    w_count_nxt = r_count + CNT_W'(1);
                end else if (w_is_term) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (w_accept && w_is_term) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_FINISH: begin
                if (enable) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_OUT: begin
                if (enable) begin
                    w_acc_nxt   = ZERO_A;
                    w_count_nxt = {CNT_W{1'b0}};
                    w_neg_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Range check and two's-complement conversion of the accumulated magnitude
    always_comb begin
        w_res     = ZERO_B;
        w_res_neg = 1'b0;
        w_res_err = 1'b0;
        if (r_err_flag) begin
            w_res_err = 1'b1;
        end else if (r_neg && (r_acc > LIM_NEG)) begin
            w_res     = SAT_NEG;
            w_res_err = 1'b1;
        end else if (!r_neg && (r_acc > LIM_POS)) begin
            w_res     = SAT_POS;
            w_res_err = 1'b1;
        end else begin
            w_res     = r_neg ? (ZERO_B - w_mag) : w_mag;
            w_res_neg = r_neg && (w_mag != ZERO_B);
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_acc       <= ZERO_A;
            r_count     <= {CNT_W{1'b0}};
            r_neg       <= 1'b0;
            r_err_flag  <= 1'b0;
            r_rdy       <= 1'b0;
            r_res       <= ZERO_B;
            r_res_neg   <= 1'b0;
            r_res_err   <= 1'b0;
            bin_out     <= ZERO_B;
            is_negative <= 1'b0;
            error       <= 1'b0;
            valid       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_count    <= w_count_nxt;
            r_neg      <= w_neg_nxt;
            r_err_flag <= w_err_nxt;
            r_rdy      <= (w_state_nxt != S_FINISH) && (w_state_nxt != S_OUT);
            if (enable && (r_state == S_FINISH)) begin
                r_res     <= w_res;
                r_res_neg <= w_res_neg;
                r_res_err <= w_res_err;
            end
            if (enable && (r_state == S_OUT)) begin
                bin_out     <= r_res;
                is_negative <= r_res_neg;
                error       <= r_res_err;
                valid       <= 1'b1;
            end else begin
                valid       <= 1'b0;
            end
        end
    end

endmodule
